// File: rtl/fsm_pkg.sv
// Shared types for the five-state sequencing controller: state encoding,
// the registered output bundle, and the per-state output decode.
package fsm_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S1    = 3'd1,
        S2    = 3'd2,
        S3    = 3'd3,
        ERROR = 3'd4
    } state_t;

    typedef struct packed {
        logic err;
        logic n_o1;
        logic o2;
        logic o3;
        logic o4;
    } out_t;

    localparam out_t OUT_IDLE  = '{err: 1'b0, n_o1: 1'b1, o2: 1'b0, o3: 1'b0, o4: 1'b0};
    localparam out_t OUT_S1    = '{err: 1'b0, n_o1: 1'b0, o2: 1'b1, o3: 1'b0, o4: 1'b0};
    localparam out_t OUT_S2    = '{err: 1'b0, n_o1: 1'b1, o2: 1'b1, o3: 1'b1, o4: 1'b0};
    localparam out_t OUT_S3    = '{err: 1'b0, n_o1: 1'b1, o2: 1'b0, o3: 1'b0, o4: 1'b1};
    localparam out_t OUT_ERROR = '{err: 1'b1, n_o1: 1'b1, o2: 1'b0, o3: 1'b0, o4: 1'b0};

    // Unused encodings decode to the IDLE values so recovery is clean.
    function automatic out_t state_outputs(input state_t s);
        out_t o;
        case (s)
            IDLE:    o = OUT_IDLE;
            S1:      o = OUT_S1;
            S2:      o = OUT_S2;
            S3:      o = OUT_S3;
            ERROR:   o = OUT_ERROR;
            default: o = OUT_IDLE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/fsm.sv
// Moore controller sequencing i1..i4 through IDLE/S1/S2/S3/ERROR with
// registered, glitch-free state-decoded outputs.
module fsm
    import fsm_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i1,
    input  logic i2,
    input  logic i3,
    input  logic i4,
    output logic err,
    output logic n_o1,
    output logic o2,
    output logic o3,
    output logic o4
);

    state_t state_q;
    state_t state_d;
    out_t   out_q;
    out_t   out_d;

    // Priority-ordered transitions; first matching condition wins.
    always_comb begin : next_state_logic
        state_d = IDLE;
        case (state_q)
            IDLE: begin
                if (!i1)     state_d = IDLE;
                else if (i2) state_d = S1;
                else if (i3) state_d = S2;
                else         state_d = ERROR;
            end
            S1: begin
                if (!i2)     state_d = S1;
                else if (i3) state_d = S2;
                else if (i4) state_d = S3;
                else         state_d = ERROR;
            end
            S2: begin
                if (i3)      state_d = S2;
                else if (i4) state_d = S3;
                else         state_d = ERROR;
            end
            S3: begin
                if (!i1)     state_d = IDLE;
                else if (i2) state_d = ERROR;
                else         state_d = S3;
            end
            ERROR: begin
                if (i1)      state_d = ERROR;
                else         state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are loaded from the next-state decode so they line up with
    // the state register and never see a combinational input path.
    always_comb begin : next_output_logic
        out_d = OUT_IDLE;
        out_d = state_outputs(state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= OUT_IDLE;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign err  = out_q.err;
    assign n_o1 = out_q.n_o1;
    assign o2   = out_q.o2;
    assign o3   = out_q.o3;
    assign o4   = out_q.o4;

endmodule

// File: tb/tb_fsm.sv
// Directed plus random bench for fsm: expected outputs are queued when a
// step is driven and popped when the registered outputs are sampled.
module tb_fsm;

    logic clk;
    logic rst;
    logic i1, i2, i3, i4;
    logic err, n_o1, o2, o3, o4;

    int n_checks;
    int n_fail;

    // Reference model state codes and output vectors {err,n_o1,o2,o3,o4}.
    localparam int M_IDLE = 0;
    localparam int M_S1   = 1;
    localparam int M_S2   = 2;
    localparam int M_S3   = 3;
    localparam int M_ERR  = 4;

    localparam logic [4:0] V_IDLE = 5'b01000;
    localparam logic [4:0] V_S1   = 5'b00100;
    localparam logic [4:0] V_S2   = 5'b01110;
    localparam logic [4:0] V_S3   = 5'b01001;
    localparam logic [4:0] V_ERR  = 5'b11000;

    logic [4:0] exp_q[$];
    int         model_state;
    logic [4:0] last_exp;

    fsm dut (
        .clk  (clk),
        .rst  (rst),
        .i1   (i1),
        .i2   (i2),
        .i3   (i3),
        .i4   (i4),
        .err  (err),
        .n_o1 (n_o1),
        .o2   (o2),
        .o3   (o3),
        .o4   (o4)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] model_out(input int s);
        case (s)
            M_S1:    return V_S1;
            M_S2:    return V_S2;
            M_S3:    return V_S3;
            M_ERR:   return V_ERR;
            default: return V_IDLE;
        endcase
    endfunction

    function automatic int model_next(input int s, input logic [3:0] in);
        logic a, b, c, d;
        {a, b, c, d} = in;
        case (s)
            M_IDLE: return !a ? M_IDLE : b ? M_S1 : c ? M_S2 : M_ERR;
            M_S1:   return !b ? M_S1 : c ? M_S2 : d ? M_S3 : M_ERR;
            M_S2:   return c ? M_S2 : d ? M_S3 : M_ERR;
            M_S3:   return !a ? M_IDLE : b ? M_ERR : M_S3;
            default: return a ? M_ERR : M_IDLE;
        endcase
    endfunction

    function automatic logic [4:0] dut_out();
        return {err, n_o1, o2, o3, o4};
    endfunction

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed err/n_o1/o2/o3/o4=%b expected %b", tag, obs, expv);
        end
    endtask

    // Driver: called just after a rising edge. Applies inputs, confirms
    // outputs do not move before the edge, then checks the queued result.
    task automatic step(input string tag, input logic [3:0] in);
        logic [4:0] expv;
        {i1, i2, i3, i4} = in;
        model_state = model_next(model_state, in);
        exp_q.push_back(model_out(model_state));
        #2;
        check({tag, "_hold"}, dut_out(), last_exp);
        @(posedge clk);
        #1;
        expv = exp_q.pop_front();
        check(tag, dut_out(), expv);
        last_exp = expv;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_state = M_IDLE;
        last_exp = V_IDLE;

        // Reset with arbitrary inputs
        rst = 1'b1;
        {i1, i2, i3, i4} = 4'($urandom_range(0, 15));
        repeat (2) @(posedge clk);
        #1;
        check("reset_idle", dut_out(), V_IDLE);
        rst = 1'b0;

        // Main path
        step("main_s1",      4'b1100);
        step("main_s2",      4'b0110);
        step("main_s3",      4'b0001);
        step("main_s3_hold", 4'b1000);
        step("main_idle",    4'b0000);

        // IDLE error entry, sticky, exit via IDLE
        step("idle_to_err",  4'b1000);
        step("err_sticky",   4'b1010);
        step("err_to_idle",  4'b0000);

        // S3 error entry
        step("to_s2",        4'b1010);
        step("to_s3",        4'b0001);
        step("s3_to_err",    4'b1100);
        step("err_exit",     4'b0000);

        // S1 hold, S1 error entry
        step("to_s1",        4'b1100);
        step("s1_hold",      4'b0000);
        step("s1_to_err",    4'b0100);
        step("err_exit2",    4'b0000);

        // S1 direct to S3, IDLE direct to S2
        step("to_s1b",       4'b1100);
        step("s1_to_s3",     4'b0101);
        step("s3_to_idle",   4'b0000);
        step("idle_to_s2",   4'b1010);

        // Asynchronous reset while in S2: takes effect before the next edge
        rst = 1'b1;
        #1;
        check("async_rst_s2", dut_out(), V_IDLE);
        model_state = M_IDLE;
        last_exp = V_IDLE;
        @(posedge clk);
        #1;
        check("rst_held_idle", dut_out(), V_IDLE);
        rst = 1'b0;

        // Priority resolution and ERROR exit never skipping IDLE
        step("prio_idle_s1", 4'b1110);
        step("prio_s1_s2",   4'b0111);
        step("s2_hold",      4'b0010);
        step("s2_to_err",    4'b0000);
        step("err_hold_all", 4'b1111);
        step("err_not_s1",   4'b0110);

        // Random walk against the model
        for (int k = 0; k < 60; k++) begin
            step("rand", 4'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fsm.md
# fsm

Five-state Moore controller (IDLE, S1, S2, S3, ERROR) that sequences four level inputs, `i1`..`i4`, into four status outputs and an error flag. All outputs are registered and change only on clock edges, so downstream logic sees glitch-free, state-decoded signals. It is a standalone control block with no datapath.

## Interface
Parameters:
- none

Ports:
- `clk` — input, 1 bit. Rising-edge clock.
- `rst` — input, 1 bit. Asynchronous, active-high reset. Forces IDLE and the IDLE output values.
- `i1` — input, 1 bit. Start / hold qualifier.
- `i2` — input, 1 bit. Advance qualifier.
- `i3` — input, 1 bit. Path-select qualifier.
- `i4` — input, 1 bit. Secondary path qualifier.
- `err` — output, 1 bit. High while in ERROR.
- `n_o1` — output, 1 bit. Active-low. Low only in S1.
- `o2` — output, 1 bit. High in S1 and S2.
- `o3` — output, 1 bit. High in S2.
- `o4` — output, 1 bit. High in S3.

## Operation
Outputs for each state, listed as err / n_o1 / o2 / o3 / o4:
- IDLE: 0 / 1 / 0 / 0 / 0
- S1: 0 / 0 / 1 / 0 / 0
- S2: 0 / 1 / 1 / 1 / 0
- S3: 0 / 1 / 0 / 0 / 1
- ERROR: 1 / 1 / 0 / 0 / 0

Transitions are evaluated in priority order, first match wins:
- IDLE: `!i1` → IDLE; `i2` → S1; `i3` → S2; otherwise → ERROR.
- S1: `!i2` → S1; `i3` → S2; `i4` → S3; otherwise → ERROR.
- S2: `i3` → S2; `i4` → S3; otherwise → ERROR.
- S3: `!i1` → IDLE; `i2` → ERROR; otherwise → S3.
- ERROR: `i1` → ERROR; otherwise → IDLE.

Encoding and recovery:
- Unused state encodings go to IDLE on the next edge and drive the IDLE output values.
- State encoding is 3-bit binary.

## Timing
- Inputs are sampled on the rising edge of `clk`.
- The next state and its outputs are registered on that same edge. Outputs therefore reflect the new state one edge after the qualifying inputs, with zero combinational input-to-output paths.
- Outputs are produced by registers loaded from the next-state decode, not decoded from the current-state register.
- Reset values: state = IDLE, `err` = 0, `n_o1` = 1, `o2` = `o3` = `o4` = 0.
- Reset asserted mid-sequence, in any state, takes effect immediately without waiting for a clock edge.
- Reset release: the first transition occurs on the first rising edge at which `rst` is low.
- Input priority resolves every combination: e.g. in IDLE, `i1`=`i2`=`i3`=1 → S1; in S1, `i2`=`i3`=`i4`=1 → S2.
- ERROR is sticky while `i1` = 1. It leaves only through IDLE, never directly to S1, S2 or S3.

## Structure
- Package `fsm_pkg` holds:
  - the `state_t` enum (IDLE, S1, S2, S3, ERROR, 3-bit), and
  - a per-state output constant struct (`err`, `n_o1`, `o2`, `o3`, `o4`).
- Single module with no sub-modules, organised as three parts:
  - an `always_comb` block for next state,
  - an `always_comb` block for next outputs,
  - one `always_ff` block with asynchronous reset for the state and output registers.

## Test plan
- **Reset:** assert `rst` with arbitrary inputs → IDLE, outputs err / n_o1 / o2 / o3 / o4 = 0 / 1 / 0 / 0 / 0. Assert `rst` again while in S2 → IDLE values appear at once, before the next edge.
- **Main path:** from IDLE, walk through the following inputs (`i1` `i2` `i3` `i4`):
  - 1100 → S1: `n_o1` = 0, `o2` = 1.
  - 0110 → S2: `o2` = `o3` = 1.
  - 0001 → S3: `o4` = 1.
  - 1000 → stays S3.
  - 0000 → IDLE.
- **IDLE error entry:** IDLE, inputs 1000 → ERROR, `err` = 1. Then 1010 → stays ERROR. Then 0000 → IDLE.
- **S3 error entry:** S3, inputs 1100 → ERROR, `err` = 1.
- **S1 error entry:** S1, inputs 0100 → ERROR.
- **S1 hold and direct paths:**
  - S1, inputs 0000 → holds S1.
  - S1, inputs 0101 → S3.
  - IDLE, inputs 1010 → S2, `o3` = 1.
